// File: rtl/omsp_alu_addseq.sv
// Multi-cycle carry-select adder: adds SEG bits per cycle, LSB segment first, then pulses done.
// Optional BCD (decimal) add per nibble when the DADD_EN macro is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; result and flags hold the last value
// ST_RUN  | one segment per cycle, registered carry selects candidate
// ST_DONE | one-cycle done pulse, then back to idle
module omsp_alu_addseq #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             dec,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int NSEG = WIDTH / SEG;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_msb, b_msb;
  logic             carry_q;
  logic [CW-1:0]    seg_cnt;
  logic             last_seg;
  logic             accept;
  logic [SEG-1:0]   seg_a, seg_b;
  logic [SEG:0]     cand0, cand1, sel;
  logic [WIDTH:0]   sum_nxt;
  logic             v_nxt;

`ifdef DADD_EN
  logic             dec_q;
  logic [SEG:0]     bcd0, bcd1;

  // Nibble-serial decimal add inside one segment; a digit carry forces the +6 correction.
  function automatic logic [SEG:0] bcd_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                           input logic c);
    logic [SEG:0] r;
    logic [4:0]   s;
    logic         cy;
    r  = '0;
    cy = c;
    for (int i = 0; i < SEG / 4; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0, cy};
      if (s > 5'd9) begin
        s  = s + 5'd6;
        cy = 1'b1;
      end else begin
        cy = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    r[SEG] = cy;
    return r;
  endfunction
`else
  logic unused_dec;
  assign unused_dec = dec;
`endif

  assign accept   = (state == ST_IDLE) && start;
  assign last_seg = (seg_cnt == CW'(NSEG - 1));
  assign seg_a    = a_q[SEG-1:0];
  assign seg_b    = b_q[SEG-1:0];

  // Both candidates are ready before the carry arrives; the carry only steers the mux.
  always_comb begin
    cand0 = {1'b0, seg_a} + {1'b0, seg_b};
    cand1 = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, 1'b1};
`ifdef DADD_EN
    bcd0 = bcd_add(seg_a, seg_b, 1'b0);
    bcd1 = bcd_add(seg_a, seg_b, 1'b1);
    if (dec_q) begin
      cand0 = bcd0;
      cand1 = bcd1;
    end
`endif
    sel = carry_q ? cand1 : cand0;
  end

  always_comb begin
    sum_nxt = sum;
    for (int k = 0; k < NSEG; k++) begin
      if (seg_cnt == CW'(k)) sum_nxt[k*SEG +: SEG] = sel[SEG-1:0];
    end
    sum_nxt[WIDTH] = sel[SEG];
    v_nxt = (a_msb == b_msb) && (sum_nxt[WIDTH-1] != a_msb);
`ifdef DADD_EN
    if (dec_q) v_nxt = 1'b0;
`endif
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_seg) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Operands shift right so the active segment always sits at bit 0.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      carry_q <= 1'b0;
      seg_cnt <= '0;
      sum     <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
`ifdef DADD_EN
      dec_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b;
      a_msb   <= op_a[WIDTH-1];
      b_msb   <= op_b[WIDTH-1];
      carry_q <= cin;
      seg_cnt <= '0;
`ifdef DADD_EN
      dec_q   <= dec;
`endif
    end else if (state == ST_RUN) begin
      a_q     <= a_q >> SEG;
      b_q     <= b_q >> SEG;
      carry_q <= sel[SEG];
      seg_cnt <= seg_cnt + CW'(1);
      sum     <= sum_nxt;
      if (last_seg) begin
        flag_c <= sum_nxt[WIDTH];
        flag_z <= (sum_nxt[WIDTH-1:0] == '0);
        flag_n <= sum_nxt[WIDTH-1];
        flag_v <= v_nxt;
      end
    end
  end

endmodule

// File: tb/tb_omsp_alu_addseq.sv
// Scoreboard bench for omsp_alu_addseq (WIDTH=16, SEG=4): directed corner cases, abort-by-reset,
// and randomized operations with spurious start pulses while busy.
module tb_omsp_alu_addseq;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int NSEG  = WIDTH / SEG;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           c, z, n, v;
    int             done_cyc;
  } exp_t;

  logic             mclk, reset_n, start, cin, dec;
  logic [WIDTH-1:0] op_a, op_b;
  logic             busy, done, flag_c, flag_z, flag_n, flag_v;
  logic [WIDTH:0]   sum;

  int   cyc = 0;
  int   free_cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  bit   have_result = 0;
  exp_t last;
  bit   prev_done = 0;

  omsp_alu_addseq #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .mclk(mclk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .cin(cin), .dec(dec), .busy(busy), .done(done), .sum(sum),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-word arithmetic, or digit-by-digit decimal with the >9 => +6 rule.
  function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                     input logic ci, input logic dc);
    exp_t        e;
    bit          use_dec;
    int unsigned s, cy, d, r;
`ifdef DADD_EN
    use_dec = dc;
`else
    use_dec = 1'b0 & dc;
`endif
    if (use_dec) begin
      cy = 32'(ci);
      r  = 0;
      for (int i = 0; i < 4; i++) begin
        d = ((32'(a) >> (4 * i)) & 15) + ((32'(b) >> (4 * i)) & 15) + cy;
        if (d > 9) begin
          d  = d + 6;
          cy = 1;
        end else begin
          cy = 0;
        end
        r = r | ((d & 15) << (4 * i));
      end
      e.sum = 17'(cy * 65536 + r);
      e.v   = 1'b0;
    end else begin
      s     = 32'(a) + 32'(b) + 32'(ci);
      e.sum = 17'(s);
      e.v   = (a[15] == b[15]) && (e.sum[15] != a[15]);
    end
    e.c        = e.sum[16];
    e.z        = (e.sum[15:0] == 16'h0);
    e.n        = e.sum[15];
    e.done_cyc = 0;
    return e;
  endfunction

  // Present start for one cycle; optionally keep firing junk starts through RUN and DONE.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic dc, input bit junk, input bit expect_done);
    exp_t e;
    int   c;
    while (cyc < free_cyc) @(negedge mclk);
    op_a  = a;
    op_b  = b;
    cin   = ci;
    dec   = dc;
    start = 1'b1;
    c     = cyc;
    if (expect_done) begin
      e          = ref_model(a, b, ci, dc);
      e.done_cyc = c + NSEG + 1;
      sb.push_back(e);
    end
    free_cyc = c + NSEG + 2;
    @(negedge mclk);
    start = 1'b0;
    if (junk) begin
      for (int k = 0; k < NSEG + 1; k++) begin
        start = 1'b1;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        cin   = 1'($urandom);
        dec   = 1'($urandom);
        @(negedge mclk);
      end
    end
    start = 1'b0;
  endtask

  always @(negedge mclk) begin
    if (reset_n) begin
      if (done) begin
        chk("done_width", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cyc);
        end else begin
          last = sb.pop_front();
          chk("latency", 32'(cyc), 32'(last.done_cyc));
          chk("sum", 32'(sum), 32'(last.sum));
          chk("flag_c", 32'(flag_c), 32'(last.c));
          chk("flag_z", 32'(flag_z), 32'(last.z));
          chk("flag_n", 32'(flag_n), 32'(last.n));
          chk("flag_v", 32'(flag_v), 32'(last.v));
          chk("busy_at_done", 32'(busy), 32'd0);
          have_result = 1'b1;
        end
      end else if (!busy && have_result) begin
        chk("hold", {11'b0, flag_c, flag_z, flag_n, flag_v, sum},
            {11'b0, last.c, last.z, last.n, last.v, last.sum});
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'd0);
    chk({tag, "_flags"}, {28'b0, flag_c, flag_z, flag_n, flag_v}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    cin     = 1'b0;
    dec     = 1'b0;
    #2 reset_n = 1'b0;
    #2 chk_reset_state("por");
    repeat (2) @(negedge mclk);
    reset_n  = 1'b1;
    free_cyc = cyc;

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef DADD_EN
    issue(16'h0999, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(16'h9999, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
`endif

    // Abort in the second RUN cycle, then accept on the first edge after release.
    issue(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge mclk);
    #2 reset_n = 1'b0;
    have_result = 1'b0;
    #1 chk_reset_state("abort");
    repeat (2) @(negedge mclk);
    reset_n  = 1'b1;
    free_cyc = cyc;
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge mclk);
    end

    repeat (NSEG + 4) @(negedge mclk);
    chk("pending", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
